// File: rtl/pe_param_pkg.sv
// Shared types and constants for the parametrised row-stationary PE.
// Holds the FSM state enum, the config field layout and the scratchpad length helpers.
package pe_param_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_FILTER,
    READ_IFMAP,
    READ_IPSUM,
    CONV,
    WRITE_OPSUM
  } state_t;

  localparam int CFG_FIELD_W  = 2;
  localparam int CFG_Q_LSB    = 0;
  localparam int CFG_P_LSB    = 2;
  localparam int CFG_RS_LSB   = 4;
  localparam int CFG_U_LSB    = 6;
  localparam int CFG_DW_BIT   = 8;
  localparam int CFG_FR_BIT   = 9;
  localparam int CFG_RELU_BIT = 10;
  localparam int CFG_F_LSB    = 11;

  // Low config fields up to first_row; relu and F are handled separately.
  typedef struct packed {
    logic                   first_row;
    logic                   depthwise;
    logic [CFG_FIELD_W-1:0] u_m1;
    logic [CFG_FIELD_W-1:0] rs_m1;
    logic [CFG_FIELD_W-1:0] p_m1;
    logic [CFG_FIELD_W-1:0] q_m1;
  } cfg_t;

  localparam int IFMAP_LEN_DEF  = 16;
  localparam int FILTER_LEN_DEF = 64;
  localparam int PSUM_LEN_DEF   = 4;

  function automatic int ifmap_len(int q_max, int rs_max);
    return q_max * rs_max;
  endfunction

  function automatic int filter_len(int p_max, int q_max, int rs_max);
    return p_max * q_max * rs_max;
  endfunction

  function automatic int psum_len(int p_max, int q_max);
    return (p_max > q_max) ? p_max : q_max;
  endfunction

  function automatic int cfg_w(int f_w);
    return CFG_F_LSB + f_w;
  endfunction

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_param_if.sv
// Stream and control bundle between the PE and its producers/consumer.
// slave is the PE side, master is the driver side.
interface pe_param_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int PSUM_W = 32,
  parameter int CFG_W  = 16
);
  logic                      PE_en;
  logic [CFG_W-1:0]          i_config;
  logic [DATA_W-1:0]         i_zp;
  logic [LANES*DATA_W-1:0]   ifmap;
  logic [LANES*DATA_W-1:0]   filter;
  logic [PSUM_W-1:0]         ipsum;
  logic                      ifmap_valid;
  logic                      filter_valid;
  logic                      ipsum_valid;
  logic                      opsum_ready;
  logic                      ifmap_ready;
  logic                      filter_ready;
  logic                      ipsum_ready;
  logic                      opsum_valid;
  logic [PSUM_W-1:0]         opsum;
  logic                      busy;
  logic                      done;
  logic                      cfg_err;

  modport slave (
    input  PE_en, i_config, i_zp, ifmap, filter, ipsum,
           ifmap_valid, filter_valid, ipsum_valid, opsum_ready,
    output ifmap_ready, filter_ready, ipsum_ready, opsum_valid, opsum,
           busy, done, cfg_err
  );

  modport master (
    output PE_en, i_config, i_zp, ifmap, filter, ipsum,
           ifmap_valid, filter_valid, ipsum_valid, opsum_ready,
    input  ifmap_ready, filter_ready, ipsum_ready, opsum_valid, opsum,
           busy, done, cfg_err
  );
endinterface

// File: rtl/pe_param_mac.sv
// Signed multiply-accumulate: filter (DATA_W) x zero-point-adjusted ifmap (DATA_W+1).
// Product is sign-extended to PSUM_W and added with wrap-around.
module pe_mac #(
  parameter int DATA_W = 8,
  parameter int PSUM_W = 32
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W:0]   b,
  input  logic signed [PSUM_W-1:0] acc_in,
  output logic signed [PSUM_W-1:0] acc_out
);
  logic signed [2*DATA_W:0] prod;

  assign prod    = a * b;
  assign acc_out = acc_in + {{(PSUM_W-2*DATA_W-1){prod[2*DATA_W]}}, prod};
endmodule

// File: rtl/pe_param.sv
// Parametrised row-stationary PE: loads filter/ifmap/psum spads, one MAC per cycle, streams opsums.
// Optional macro PE_OPSUM_RELU_EN clamps negative opsums to 0 when cfg relu=1.
module pe_param
  import pe_param_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int PSUM_W = 32,
  parameter int P_MAX  = 4,
  parameter int Q_MAX  = 4,
  parameter int RS_MAX = 4,
  parameter int F_W    = 5
) (
  input logic        clk,
  input logic        rst,
  pe_param_if.slave  bus
);
  localparam int IFMAP_LEN  = ifmap_len(Q_MAX, RS_MAX);
  localparam int FILTER_LEN = filter_len(P_MAX, Q_MAX, RS_MAX);
  localparam int PSUM_LEN   = psum_len(P_MAX, Q_MAX);
  localparam int CFG_W      = cfg_w(F_W);
  localparam int PTR_W      = $clog2(FILTER_LEN + 1);
  localparam int FA_W       = idx_w(FILTER_LEN);
  localparam int IA_W       = idx_w(IFMAP_LEN);
  localparam int PA_W       = idx_w(PSUM_LEN);
  localparam logic [PTR_W-1:0] ONE = PTR_W'(1);

  state_t            state;
  cfg_t              cfg;
  cfg_t              cfg_in;
  logic [F_W-1:0]    f_cfg;
  logic [F_W-1:0]    col_cnt;
  logic [DATA_W-1:0] zp;
  logic [PTR_W-1:0]  ptr, ifm_idx, ps_idx, out_idx;
  logic              done_r, cfg_err_r;

  logic signed [DATA_W-1:0] filter_spad [FILTER_LEN];
  logic signed [DATA_W:0]   ifmap_spad  [IFMAP_LEN];
  logic [PSUM_W-1:0]        psum_spad   [PSUM_LEN];

  logic [PTR_W-1:0]  q_n, rs_n, p_n, u_n, qrs, nf, np_n, uq;
  logic [PSUM_W-1:0] mac_out, opsum_raw, opsum_sel;

  assign cfg_in = cfg_t'(bus.i_config[CFG_FR_BIT:0]);

  assign q_n  = PTR_W'(cfg.q_m1) + ONE;
  assign p_n  = PTR_W'(cfg.p_m1) + ONE;
  assign rs_n = PTR_W'(cfg.rs_m1) + ONE;
  assign u_n  = PTR_W'(cfg.u_m1) + ONE;
  assign qrs  = q_n * rs_n;
  assign nf   = cfg.depthwise ? qrs : p_n * qrs;
  assign np_n = cfg.depthwise ? q_n : p_n;
  assign uq   = u_n * q_n;

  pe_mac #(.DATA_W(DATA_W), .PSUM_W(PSUM_W)) u_mac (
    .a      (filter_spad[FA_W'(ptr)]),
    .b      (ifmap_spad[IA_W'(ifm_idx)]),
    .acc_in (psum_spad[PA_W'(ps_idx)]),
    .acc_out(mac_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cfg       <= '0;
      f_cfg     <= '0;
      zp        <= '0;
      col_cnt   <= '0;
      ptr       <= '0;
      ifm_idx   <= '0;
      ps_idx    <= '0;
      out_idx   <= '0;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      case (state)
        IDLE: begin
          // done_r blocks a start in the cycle right after completion
          if (bus.PE_en && !done_r) begin
            cfg     <= cfg_in;
            f_cfg   <= bus.i_config[CFG_W-1:CFG_F_LSB];
            zp      <= bus.i_zp;
            ptr     <= '0;
            out_idx <= '0;
            col_cnt <= '0;
            if (cfg_in.u_m1 > cfg_in.rs_m1) cfg_err_r <= 1'b1;
            else                            state     <= READ_FILTER;
          end
        end
        READ_FILTER: if (bus.filter_valid) begin
          for (int k = 0; k < LANES; k++)
            if (PTR_W'(k) < q_n)
              filter_spad[FA_W'(ptr + PTR_W'(k))] <= bus.filter[k*DATA_W +: DATA_W];
          if (ptr + q_n == nf) begin
            ptr   <= '0;
            state <= READ_IFMAP;
          end else ptr <= ptr + q_n;
        end
        READ_IFMAP: if (bus.ifmap_valid) begin
          for (int k = 0; k < LANES; k++)
            if (PTR_W'(k) < q_n)
              ifmap_spad[IA_W'(ptr + PTR_W'(k))] <=
                {1'b0, bus.ifmap[k*DATA_W +: DATA_W]} - {1'b0, zp};
          if (ptr + q_n == qrs) begin
            ptr   <= '0;
            state <= READ_IPSUM;
          end else ptr <= ptr + q_n;
        end
        READ_IPSUM: begin
          if (cfg.first_row) begin
            for (int j = 0; j < PSUM_LEN; j++) psum_spad[PA_W'(j)] <= '0;
            ptr     <= '0;
            ifm_idx <= '0;
            ps_idx  <= '0;
            state   <= CONV;
          end else if (bus.ipsum_valid) begin
            psum_spad[PA_W'(ptr)] <= bus.ipsum;
            if (ptr + ONE == np_n) begin
              ptr     <= '0;
              ifm_idx <= '0;
              ps_idx  <= '0;
              state   <= CONV;
            end else ptr <= ptr + ONE;
          end
        end
        CONV: begin
          psum_spad[PA_W'(ps_idx)] <= mac_out;
          ptr <= ptr + ONE;
          if (cfg.depthwise) begin
            ifm_idx <= ifm_idx + ONE;
            ps_idx  <= (ps_idx + ONE == q_n) ? '0 : ps_idx + ONE;
          end else if (ifm_idx + ONE == qrs) begin
            ifm_idx <= '0;
            ps_idx  <= ps_idx + ONE;
          end else ifm_idx <= ifm_idx + ONE;
          if (ptr == nf - ONE) begin
            out_idx <= '0;
            state   <= WRITE_OPSUM;
          end
        end
        WRITE_OPSUM: if (bus.opsum_ready) begin
          if (out_idx == np_n - ONE) begin
            out_idx <= '0;
            if (col_cnt == f_cfg) begin
              done_r <= 1'b1;
              state  <= IDLE;
            end else begin
              // slide the window by U columns; only U fresh beats are fetched
              for (int j = 0; j < IFMAP_LEN; j++)
                if (PTR_W'(j) + uq < qrs)
                  ifmap_spad[IA_W'(j)] <= ifmap_spad[IA_W'(PTR_W'(j) + uq)];
                else
                  ifmap_spad[IA_W'(j)] <= '0;
              ptr     <= qrs - uq;
              col_cnt <= col_cnt + F_W'(1);
              state   <= READ_IFMAP;
            end
          end else out_idx <= out_idx + ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign opsum_raw = psum_spad[PA_W'(out_idx)];

`ifdef PE_OPSUM_RELU_EN
  logic relu_en;
  always_ff @(posedge clk) begin
    if (rst) relu_en <= 1'b0;
    else if (state == IDLE && bus.PE_en && !done_r) relu_en <= bus.i_config[CFG_RELU_BIT];
  end
  assign opsum_sel = (relu_en && opsum_raw[PSUM_W-1]) ? '0 : opsum_raw;
`else
  assign opsum_sel = opsum_raw;
`endif

  assign bus.filter_ready = (state == READ_FILTER);
  assign bus.ifmap_ready  = (state == READ_IFMAP);
  assign bus.ipsum_ready  = (state == READ_IPSUM) && !cfg.first_row;
  assign bus.opsum_valid  = (state == WRITE_OPSUM);
  assign bus.opsum        = (state == WRITE_OPSUM) ? opsum_sel : '0;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_r;
  assign bus.cfg_err      = cfg_err_r;
endmodule

// File: tb/tb_pe_param.sv
// Directed bench for pe_param: expected opsums go into a queue, a negedge monitor pops and compares.
module tb_pe_param;
  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int PSUM_W = 32;
  localparam int CFG_W  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_param_if #(.DATA_W(DATA_W), .LANES(LANES), .PSUM_W(PSUM_W), .CFG_W(CFG_W)) bus ();

  pe_param dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int fails  = 0;
  logic [PSUM_W-1:0] exp_q [$];
  logic              prev_stall = 1'b0;
  logic [PSUM_W-1:0] prev_opsum = '0;
  int ifmap_hs     = 0;
  int ipsum_rdy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.opsum_valid, 1);
        chk("hold_opsum", bus.opsum, prev_opsum);
      end
      if (!bus.opsum_valid) chk("opsum_zero_when_idle", bus.opsum, 0);
      if (bus.opsum_valid && bus.opsum_ready) begin
        if (exp_q.size() == 0) chk("opsum_unexpected", bus.opsum, 32'hDEAD_BEEF);
        else                   chk("opsum", bus.opsum, exp_q.pop_front());
      end
      if (bus.ifmap_valid && bus.ifmap_ready) ifmap_hs <= ifmap_hs + 1;
      if (bus.ipsum_ready) ipsum_rdy_cnt <= ipsum_rdy_cnt + 1;
      prev_stall <= bus.opsum_valid && !bus.opsum_ready;
      prev_opsum <= bus.opsum;
    end
  end

  function automatic logic [15:0] mkcfg(int q, int p, int rs, int u,
                                        logic dw, logic fr, logic relu, int f);
    return {5'(f), relu, fr, dw, 2'(u-1), 2'(rs-1), 2'(p-1), 2'(q-1)};
  endfunction

  function automatic logic rdy(int which);
    case (which)
      0:       return bus.filter_ready;
      1:       return bus.ifmap_ready;
      default: return bus.ipsum_ready;
    endcase
  endfunction

  task automatic start(input logic [15:0] c, input logic [7:0] z);
    @(posedge clk); #1;
    bus.PE_en = 1'b1; bus.i_config = c; bus.i_zp = z;
    @(posedge clk); #1;
    bus.PE_en = 1'b0;
  endtask

  task automatic send(input int which, input logic [31:0] data);
    int n = 0;
    case (which)
      0:       begin bus.filter = data; bus.filter_valid = 1'b1; end
      1:       begin bus.ifmap  = data; bus.ifmap_valid  = 1'b1; end
      default: begin bus.ipsum  = data; bus.ipsum_valid  = 1'b1; end
    endcase
    @(negedge clk);
    while (!rdy(which) && n < 100) begin n++; @(negedge clk); end
    if (!rdy(which)) chk($sformatf("send_timeout_%0d", which), 0, 1);
    @(posedge clk); #1;
    bus.filter_valid = 1'b0; bus.ifmap_valid = 1'b0; bus.ipsum_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.opsum_valid && n < 200) begin n++; @(negedge clk); end
    if (!bus.opsum_valid) chk(name, 0, 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.done && n < 300) begin n++; @(negedge clk); end
    chk(name, bus.done, 1);
  endtask

  task automatic run_depthwise(input string tag);
    int ip0;
    ip0 = ipsum_rdy_cnt;
    exp_q.push_back(26);
    exp_q.push_back(44);
    start(mkcfg(2, 1, 2, 1, 1'b1, 1'b1, 1'b0, 0), 8'd0);
    send(0, 32'h0000_0201);
    send(0, 32'h0000_0403);
    send(1, 32'h0000_0605);
    send(1, 32'h0000_0807);
    wait_done({tag, "_done"});
    chk({tag, "_ipsum_ready_never"}, ipsum_rdy_cnt - ip0, 0);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int hs0;
    rst = 1'b1;
    bus.PE_en = 1'b0; bus.i_config = '0; bus.i_zp = '0;
    bus.ifmap = '0; bus.filter = '0; bus.ipsum = '0;
    bus.ifmap_valid = 1'b0; bus.filter_valid = 1'b0; bus.ipsum_valid = 1'b0;
    bus.opsum_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_opsum_valid", bus.opsum_valid, 0);
    chk("rst_readys", {bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready}, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);

    // normal mode, zp=128, ipsum gaps and 3-cycle opsum backpressure
    exp_q.push_back(24);
    exp_q.push_back(22);
    bus.opsum_ready = 1'b0;
    start(mkcfg(1, 2, 3, 1, 1'b0, 1'b0, 1'b0, 0), 8'd128);
    chk("normal_busy", bus.busy, 1);
    send(0, 32'd1); send(0, 32'd2); send(0, 32'd3);
    send(0, 32'h0000_00FF); send(0, 32'd0); send(0, 32'd1);
    send(1, 32'd129); send(1, 32'd130); send(1, 32'd131);
    send(2, 32'd10);
    repeat (3) @(posedge clk);
    #1;
    send(2, 32'd20);
    wait_valid("normal_opsum_valid");
    repeat (3) @(posedge clk);
    #1 bus.opsum_ready = 1'b1;
    wait_done("normal_done");
    chk("normal_busy_at_done", bus.busy, 0);
    bus.PE_en = 1'b1;
    @(posedge clk); #1;
    bus.PE_en = 1'b0;
    @(negedge clk);
    chk("no_start_in_done_cycle", bus.busy, 0);
    chk("done_one_cycle", bus.done, 0);
    chk("normal_queue_empty", exp_q.size(), 0);

    run_depthwise("dw");

    // stride 2, two columns
    hs0 = ifmap_hs;
    exp_q.push_back(6);
    exp_q.push_back(12);
    start(mkcfg(1, 1, 3, 2, 1'b0, 1'b1, 1'b0, 1), 8'd0);
    send(0, 32'd1); send(0, 32'd1); send(0, 32'd1);
    send(1, 32'd1); send(1, 32'd2); send(1, 32'd3);
    send(1, 32'd4); send(1, 32'd5);
    wait_done("stride_done");
    chk("stride_ifmap_beats", ifmap_hs - hs0, 5);
    chk("stride_queue_empty", exp_q.size(), 0);

    // four lanes, full unsigned ifmap range against a negative filter
    exp_q.push_back(-32650);
    start(mkcfg(4, 1, 1, 1, 1'b0, 1'b1, 1'b0, 0), 8'd0);
    send(0, 32'h0480_FE01);
    send(1, 32'h05FF_140A);
    wait_done("wide_done");
    chk("wide_queue_empty", exp_q.size(), 0);

    // rejected start: U=3 > rs=2
    start(mkcfg(1, 1, 2, 3, 1'b0, 1'b0, 1'b0, 0), 8'd0);
    @(negedge clk);
    chk("cfg_err_pulse", bus.cfg_err, 1);
    chk("cfg_err_busy", bus.busy, 0);
    chk("cfg_err_readys", {bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready}, 0);
    @(negedge clk);
    chk("cfg_err_one_cycle", bus.cfg_err, 0);
    chk("cfg_err_busy_after", bus.busy, 0);

    // reset while stalled in WRITE_OPSUM, then a clean restart
    exp_q.push_back(26);
    exp_q.push_back(44);
    bus.opsum_ready = 1'b0;
    start(mkcfg(2, 1, 2, 1, 1'b1, 1'b1, 1'b0, 0), 8'd0);
    send(0, 32'h0000_0201);
    send(0, 32'h0000_0403);
    send(1, 32'h0000_0605);
    send(1, 32'h0000_0807);
    wait_valid("abort_opsum_valid");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    bus.opsum_ready = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_opsum_valid", bus.opsum_valid, 0);
    chk("abort_opsum", bus.opsum, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_readys", {bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready}, 0);
    run_depthwise("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
